// File: rtl/freq_calc.sv
// freq_calc: turns each new (sig_cnt, ref_cnt) pair from the frequency counter
// into an integer frequency, freq_hz = floor(sig_cnt * REF_CLK_HZ / ref_cnt),
// using a 32-step shift-add multiply followed by a 64-step restoring divide.
module freq_calc #(
    parameter logic [31:0] REF_CLK_HZ = 32'd100_000_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [31:0] sig_cnt,
    input  logic [31:0] ref_cnt,
    output logic [31:0] freq_hz,
    output logic        freq_valid,
    output logic        busy,
    output logic        div_zero,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] sig_prev_q, sig_prev_d;
    logic [31:0] ref_prev_q, ref_prev_d;
    logic [31:0] freq_hz_q, freq_hz_d;
    logic        freq_valid_q, freq_valid_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q, ovf_d;

    logic        pair_changed;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic        rem_ge;

    // The multiplier keeps the product in acc: the upper half accumulates the
    // partial sum while the lower half holds the not-yet-consumed sig_cnt bits.
    // The divider reuses acc: dividend bits shift out of the top while
    // quotient bits shift in at the bottom.
    assign pair_changed = (sig_cnt != sig_prev_q) || (ref_cnt != ref_prev_q);
    assign mul_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, REF_CLK_HZ} : 33'd0);
    assign rem_shift    = {rem_q, acc_q[63]};
    assign rem_ge       = rem_shift >= {1'b0, divisor_q};

    // State and datapath registers; synchronous reset clears everything and
    // aborts any computation in flight.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            divisor_q    <= '0;
            sig_prev_q   <= '0;
            ref_prev_q   <= '0;
            freq_hz_q    <= '0;
            freq_valid_q <= 1'b0;
            div_zero_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            divisor_q    <= divisor_d;
            sig_prev_q   <= sig_prev_d;
            ref_prev_q   <= ref_prev_d;
            freq_hz_q    <= freq_hz_d;
            freq_valid_q <= freq_valid_d;
            div_zero_q   <= div_zero_d;
            ovf_q        <= ovf_d;
        end
    end

    // Next-state: fixed 32 multiply steps, 64 divide steps, one result cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pair_changed) state_d = MUL;
            MUL:  if (cnt_q == 6'd31) state_d = DIV;
            DIV:  if (cnt_q == 6'd63) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result registers for each state.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        divisor_d    = divisor_q;
        sig_prev_d   = sig_prev_q;
        ref_prev_d   = ref_prev_q;
        freq_hz_d    = freq_hz_q;
        freq_valid_d = 1'b0;
        div_zero_d   = div_zero_q;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: begin
                if (pair_changed) begin
                    sig_prev_d = sig_cnt;
                    ref_prev_d = ref_cnt;
                    divisor_d  = ref_cnt;
                    acc_d      = {32'd0, sig_cnt};
                    rem_d      = '0;
                    cnt_d      = '0;
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
            end
            DIV: begin
                if (rem_ge) begin
                    rem_d = rem_shift[31:0] - divisor_q;
                    acc_d = {acc_q[62:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    acc_d = {acc_q[62:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
            end
            DONE: begin
                freq_valid_d = 1'b1;
                if (divisor_q == 32'd0) begin
                    freq_hz_d  = '0;
                    div_zero_d = 1'b1;
                    ovf_d      = 1'b0;
                end else if (acc_q[63:32] != 32'd0) begin
                    freq_hz_d  = 32'hFFFF_FFFF;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b1;
                end else begin
                    freq_hz_d  = acc_q[31:0];
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers; busy covers MUL, DIV and DONE.
    always_comb begin
        freq_hz    = freq_hz_q;
        freq_valid = freq_valid_q;
        div_zero   = div_zero_q;
        ovf        = ovf_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_freq_calc.sv
// Testbench for freq_calc: directed count pairs with hand-computed frequencies,
// fixed-latency checks, drop-intermediate-pair behaviour and mid-run reset.
module tb_freq_calc;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sig_cnt = '0;
    logic [31:0] ref_cnt = '0;
    logic [31:0] freq_hz;
    logic        freq_valid;
    logic        busy;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int v0 = 0;
    logic seen_100k = 1'b0;

    freq_calc dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .sig_cnt    (sig_cnt),
        .ref_cnt    (ref_cnt),
        .freq_hz    (freq_hz),
        .freq_valid (freq_valid),
        .busy       (busy),
        .div_zero   (div_zero),
        .ovf        (ovf)
    );

    // 100 MHz-style free-running clock.
    always #5 sys_clk = ~sys_clk;

    // Advance one edge and sample outputs 1 time unit later.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (freq_valid) valid_cnt++;
        if (freq_hz == 32'd100_000) seen_100k = 1'b1;
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] r);
        sig_cnt = s;
        ref_cnt = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Apply a new pair, then check busy across the run and the result at k+97.
    task automatic runCompute(input string tag, input logic [31:0] s, input logic [31:0] r,
                              input logic [31:0] exp_hz, input logic exp_dz, input logic exp_ovf);
        int vstart;
        applyStimulus(s, r);
        tick();
        checkOutput({tag, "_busy_k"}, {31'd0, busy}, 32'd1);
        vstart = valid_cnt;
        repeat (96) tick();
        checkOutput({tag, "_busy_k96"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_no_early_valid"}, valid_cnt - vstart, 32'd0);
        tick();
        checkOutput({tag, "_valid"}, {31'd0, freq_valid}, 32'd1);
        checkOutput({tag, "_hz"}, freq_hz, exp_hz);
        checkOutput({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
        checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        tick();
        checkOutput({tag, "_valid_pulse"}, {31'd0, freq_valid}, 32'd0);
        checkOutput({tag, "_hz_hold"}, freq_hz, exp_hz);
    endtask

    initial begin
        $display("[TB] freq_calc directed test start");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_hz", freq_hz, 32'd0);
        checkOutput("rst_valid", {31'd0, freq_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_dz", {31'd0, div_zero}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        checkOutput("idle_no_capture", {31'd0, busy}, 32'd0);

        // 1000 * 1e8 / 2e6 = 50_000
        runCompute("t1", 32'd1000, 32'd2_000_000, 32'd50_000, 1'b0, 1'b0);

        // 3e8 / 7 = 42_857_142.857 -> truncated
        runCompute("t2", 32'd3, 32'd7, 32'd42_857_142, 1'b0, 1'b0);
        v0 = valid_cnt;
        repeat (500) tick();
        checkOutput("t2_hold_no_valid", valid_cnt - v0, 32'd0);
        checkOutput("t2_hold_busy", {31'd0, busy}, 32'd0);

        // Divide by zero
        runCompute("t3", 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);

        // Saturating overflow
        runCompute("t4", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Zero signal count with valid reference
        runCompute("t4b", 32'd0, 32'd5, 32'd0, 1'b0, 1'b0);

        // Changes while busy: only the latest pair is computed afterwards
        v0 = valid_cnt;
        seen_100k = 1'b0;
        applyStimulus(32'd1000, 32'd2_000_000);
        tick();
        repeat (39) tick();
        applyStimulus(32'd2000, 32'd2_000_000);
        repeat (20) tick();
        applyStimulus(32'd3000, 32'd2_000_000);
        repeat (38) tick();
        checkOutput("t5_valid1", {31'd0, freq_valid}, 32'd1);
        checkOutput("t5_hz1", freq_hz, 32'd50_000);
        tick();
        checkOutput("t5_recapture_busy", {31'd0, busy}, 32'd1);
        repeat (96) tick();
        checkOutput("t5_hz_before2", freq_hz, 32'd50_000);
        tick();
        checkOutput("t5_valid2", {31'd0, freq_valid}, 32'd1);
        checkOutput("t5_hz2", freq_hz, 32'd150_000);
        repeat (10) tick();
        checkOutput("t5_two_pulses", valid_cnt - v0, 32'd2);
        checkOutput("t5_no_100k", {31'd0, seen_100k}, 32'd0);

        // Reset mid-computation
        v0 = valid_cnt;
        applyStimulus(32'd1000, 32'd2_000_000);
        tick();
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_hz", freq_hz, 32'd0);
        checkOutput("t6_rst_valid", {31'd0, freq_valid}, 32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_dz", {31'd0, div_zero}, 32'd0);
        checkOutput("t6_rst_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("t6_no_valid", valid_cnt - v0, 32'd0);
        runCompute("t6", 32'd1000, 32'd2_000_000, 32'd50_000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
